// File: rtl/sram16x8_port_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the SRAM port arbiter.
package sram16x8_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 32'd4;
    localparam int DATA_W_DEF = 32'd8;

    // GNT-to-RVALID latency; the response pipe holds RD_LAT-1 stages before the output register.
    localparam int RD_LAT     = 32'd3;
    localparam int PIPE_DEPTH = RD_LAT - 32'd1;

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        RMW_RD    = 2'd1,
        RMW_WAIT  = 2'd2,
        RMW_MERGE = 2'd3
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/sram16x8_port_arbiter_if.sv
// Requester-side bus of the SRAM port arbiter: requests in, grants and read responses out.
interface sram16x8_port_arbiter_if
    import sram16x8_port_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        rwe;
    logic [NREQ*ADDR_W-1:0] raddr;
    logic [NREQ*DATA_W-1:0] rwdata;
    logic [NREQ*DATA_W-1:0] rwmask;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rvalid;
    logic [DATA_W-1:0]      rdata;

    modport master (
        output req, rwe, raddr, rwdata, rwmask,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, rwe, raddr, rwdata, rwmask,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/sram16x8_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker; the rotating pointer is owned by the parent.
module sram16x8_port_arbiter_rr_arbiter
    import sram16x8_port_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);

    // Search from ptr upwards with wrap and take the first active requester.
    always_comb begin
        int   cand;
        logic found;
        gnt   = {NREQ{1'b0}};
        idx   = {IDX_W{1'b0}};
        found = 1'b0;
        cand  = 32'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (en && !found && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
                found     = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/sram16x8_port_arbiter.sv
// Round-robin sharing of one SRAM wrapper port; partial-mask writes become read-modify-write.
module sram16x8_port_arbiter
    import sram16x8_port_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    sram16x8_port_arbiter_if.slave bus,
    output logic                   mce,
    output logic                   mwe,
    output logic [ADDR_W-1:0]      ma,
    output logic [DATA_W-1:0]      md,
    output logic [DATA_W-1:0]      mwem,
    input  logic [DATA_W-1:0]      mq
);

    localparam int                IDX_W    = idx_width(NREQ);
    localparam logic [DATA_W-1:0] ONES     = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] ZEROS    = {DATA_W{1'b0}};
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NREQ - 1);

    function automatic logic [DATA_W-1:0] rmw_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [DATA_W-1:0] mask
    );
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    state_t                         state_r;
    logic [IDX_W-1:0]               ptr_r;
    logic [NREQ-1:0]                gnt_s;
    logic [IDX_W-1:0]               win_s;
    logic                           arb_en_s;
    logic                           accept_s;
    logic                           win_we_s;
    logic [ADDR_W-1:0]              win_addr_s;
    logic [DATA_W-1:0]              win_data_s;
    logic [DATA_W-1:0]              win_mask_s;
    logic [ADDR_W-1:0]              rmw_addr_r;
    logic [DATA_W-1:0]              rmw_data_r;
    logic [DATA_W-1:0]              rmw_mask_r;
    logic                           mce_r;
    logic                           mwe_r;
    logic [ADDR_W-1:0]              ma_r;
    logic [DATA_W-1:0]              md_r;
    logic [PIPE_DEPTH-1:0]          pipe_vld_r;
    logic [PIPE_DEPTH-1:0][IDX_W-1:0] pipe_id_r;
    logic [NREQ-1:0]                rvalid_r;
    logic [DATA_W-1:0]              rdata_r;

    assign arb_en_s = (state_r == ARB);

    sram16x8_port_arbiter_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req (bus.req),
        .ptr (ptr_r),
        .en  (arb_en_s),
        .gnt (gnt_s),
        .idx (win_s)
    );

    assign accept_s   = |gnt_s;
    assign win_we_s   = bus.rwe[win_s];
    assign win_addr_s = bus.raddr[int'(win_s) * ADDR_W +: ADDR_W];
    assign win_data_s = bus.rwdata[int'(win_s) * DATA_W +: DATA_W];
    assign win_mask_s = bus.rwmask[int'(win_s) * DATA_W +: DATA_W];

    // Control FSM: issues the memory command for each accepted request and sequences RMW.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ARB;
            ptr_r      <= {IDX_W{1'b0}};
            mce_r      <= 1'b0;
            mwe_r      <= 1'b0;
            ma_r       <= {ADDR_W{1'b0}};
            md_r       <= {DATA_W{1'b0}};
            rmw_addr_r <= {ADDR_W{1'b0}};
            rmw_data_r <= {DATA_W{1'b0}};
            rmw_mask_r <= {DATA_W{1'b0}};
        end else begin
            mce_r <= 1'b0;
            mwe_r <= 1'b0;
            case (state_r)
                ARB: begin
                    if (accept_s) begin
                        ptr_r <= (win_s == LAST_IDX) ? {IDX_W{1'b0}} : (win_s + 1'b1);
                        if (!win_we_s) begin
                            mce_r <= 1'b1;
                            ma_r  <= win_addr_s;
                        end else if (win_mask_s == ONES) begin
                            mce_r <= 1'b1;
                            mwe_r <= 1'b1;
                            ma_r  <= win_addr_s;
                            md_r  <= win_data_s;
                        end else if (win_mask_s == ZEROS) begin
                            // Nothing to write: the grant alone retires the request.
                            mce_r <= 1'b0;
                        end else begin
                            mce_r      <= 1'b1;
                            ma_r       <= win_addr_s;
                            rmw_addr_r <= win_addr_s;
                            rmw_data_r <= win_data_s;
                            rmw_mask_r <= win_mask_s;
                            state_r    <= RMW_RD;
                        end
                    end else begin
                        ptr_r <= ptr_r;
                    end
                end
                RMW_RD: begin
                    state_r <= RMW_WAIT;
                end
                RMW_WAIT: begin
                    state_r <= RMW_MERGE;
                end
                RMW_MERGE: begin
                    // MQ still holds the RMW read word: no other access was issued since.
                    mce_r   <= 1'b1;
                    mwe_r   <= 1'b1;
                    ma_r    <= rmw_addr_r;
                    md_r    <= rmw_merge(mq, rmw_data_r, rmw_mask_r);
                    state_r <= ARB;
                end
                default: begin
                    state_r <= ARB;
                end
            endcase
        end
    end

    // Read response pipe: carries the requester id alongside the read until MQ is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_r <= {PIPE_DEPTH{1'b0}};
            pipe_id_r  <= {(PIPE_DEPTH * IDX_W){1'b0}};
            rvalid_r   <= {NREQ{1'b0}};
            rdata_r    <= {DATA_W{1'b0}};
        end else begin
            pipe_vld_r[0] <= accept_s & ~win_we_s;
            pipe_id_r[0]  <= win_s;
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                pipe_vld_r[s] <= pipe_vld_r[s-1];
                pipe_id_r[s]  <= pipe_id_r[s-1];
            end
            rvalid_r <= {NREQ{1'b0}};
            if (pipe_vld_r[PIPE_DEPTH-1]) begin
                rvalid_r[pipe_id_r[PIPE_DEPTH-1]] <= 1'b1;
                rdata_r                           <= mq;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign bus.gnt    = gnt_s;
    assign bus.rvalid = rvalid_r;
    assign bus.rdata  = rdata_r;
    assign mce        = mce_r;
    assign mwe        = mwe_r;
    assign ma         = ma_r;
    assign md         = md_r;
    assign mwem       = ONES;

endmodule

// File: tb/tb_sram16x8_port_arbiter.sv
// Scoreboard bench: a behavioural SRAM, a shadow memory and an expected grant/command/response model.
module tb_sram16x8_port_arbiter;

    localparam int NREQ = 4;

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] mask;
    } op_t;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         due;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       mce;
    logic       mwe;
    logic [3:0] ma;
    logic [7:0] md;
    logic [7:0] mwem;
    logic [7:0] mq;
    logic [7:0] mem [16];

    int   cyc       = 0;
    int   n_vec     = 0;
    int   n_bad     = 0;
    logic mon_en    = 1'b0;
    logic in_run    = 1'b0;
    int   exp_ptr   = 0;
    int   block_cnt = 0;

    op_t        opq [NREQ][$];
    rsp_t       sb [$];
    logic [13:0] exp_cmd [int];
    logic [7:0] shadow [16];

    sram16x8_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(4), .DATA_W(8)) bus ();

    sram16x8_port_arbiter #(.NREQ(NREQ), .ADDR_W(4), .DATA_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .mce  (mce),
        .mwe  (mwe),
        .ma   (ma),
        .md   (md),
        .mwem (mwem),
        .mq   (mq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mce) begin
            if (mwe) mem[ma] <= md;
            else     mq      <= mem[ma];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", tag, cyc, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int ops_pending();
        int n = 0;
        for (int i = 0; i < NREQ; i++) n += opq[i].size();
        return n;
    endfunction

    task automatic add_op(input int r, input logic we, input logic [3:0] a,
                          input logic [7:0] d, input logic [7:0] m);
        op_t o;
        o.we = we; o.addr = a; o.data = d; o.mask = m;
        opq[r].push_back(o);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive queued ops, check every grant, push expected commands and responses.
    task automatic run_ops(input int max_cyc, output int used);
        int         w;
        op_t        o;
        logic [7:0] nv;
        used   = 0;
        in_run = 1'b1;
        while (ops_pending() > 0 && used < max_cyc) begin
            for (int i = 0; i < NREQ; i++) begin
                if (opq[i].size() > 0) begin
                    o = opq[i][0];
                    bus.req[i]            = 1'b1;
                    bus.rwe[i]            = o.we;
                    bus.raddr[i*4 +: 4]   = o.addr;
                    bus.rwdata[i*8 +: 8]  = o.data;
                    bus.rwmask[i*8 +: 8]  = o.mask;
                end else begin
                    bus.req[i] = 1'b0;
                end
            end
            @(negedge clk);
            if (block_cnt > 0) begin
                w = -1;
                block_cnt--;
            end else begin
                w = rr_pick(bus.req, exp_ptr);
            end
            check_val("gnt", {28'h0, bus.gnt}, (w < 0) ? 32'h0 : (32'h1 << w));
            if (w >= 0) begin
                o = opq[w].pop_front();
                exp_ptr = (w + 1) % NREQ;
                if (!o.we) begin
                    sb.push_back('{w, shadow[o.addr], cyc + 3});
                    exp_cmd[cyc + 1] = {1'b1, 1'b0, o.addr, 8'h00};
                end else if (o.mask == 8'hFF) begin
                    shadow[o.addr]   = o.data;
                    exp_cmd[cyc + 1] = {1'b1, 1'b1, o.addr, o.data};
                end else if (o.mask != 8'h00) begin
                    nv               = (shadow[o.addr] & ~o.mask) | (o.data & o.mask);
                    exp_cmd[cyc + 1] = {1'b1, 1'b0, o.addr, 8'h00};
                    exp_cmd[cyc + 4] = {1'b1, 1'b1, o.addr, nv};
                    shadow[o.addr]   = nv;
                    block_cnt        = 3;
                end
            end
            @(posedge clk);
            #1;
            used++;
        end
        bus.req = 4'h0;
        in_run  = 1'b0;
        check_val("run_done", ops_pending(), 32'h0);
        for (int i = 0; i < NREQ; i++) opq[i].delete();
    endtask

    // Per-cycle monitor: memory command bus, read responses and idle grants.
    always @(negedge clk) begin : mon
        logic [13:0] ec;
        rsp_t        r;
        if (mon_en) begin
            if (exp_cmd.exists(cyc)) begin
                ec = exp_cmd[cyc];
                exp_cmd.delete(cyc);
            end else begin
                ec = 14'h0;
            end
            check_val("mem_cmd", {18'h0, mce, mwe, (mce ? ma : 4'h0), (mwe ? md : 8'h00)}, {18'h0, ec});
            if (sb.size() > 0 && sb[0].due == cyc) begin
                r = sb.pop_front();
                check_val("rvalid", {28'h0, bus.rvalid}, 32'h1 << r.id);
                check_val("rdata", {24'h0, bus.rdata}, {24'h0, r.data});
            end else begin
                check_val("rvalid_idle", {28'h0, bus.rvalid}, 32'h0);
            end
            if (!in_run) check_val("gnt_idle", {28'h0, bus.gnt}, 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         used;
        logic [7:0] saved;
        rst        = 1'b1;
        bus.req    = 4'h0;
        bus.rwe    = 4'h0;
        bus.raddr  = 16'h0;
        bus.rwdata = 32'h0;
        bus.rwmask = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_gnt",    {28'h0, bus.gnt},    32'h0);
        check_val("rst_rvalid", {28'h0, bus.rvalid}, 32'h0);
        check_val("rst_rdata",  {24'h0, bus.rdata},  32'h0);
        check_val("rst_mce",    {31'h0, mce},        32'h0);
        check_val("rst_mwe",    {31'h0, mwe},        32'h0);
        check_val("rst_ma",     {28'h0, ma},         32'h0);
        check_val("rst_md",     {24'h0, md},         32'h0);
        check_val("mwem",       {24'h0, mwem},       32'hFF);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Full write then read-back of addr 3.
        add_op(0, 1'b1, 4'd3, 8'hA5, 8'hFF);
        run_ops(10, used);
        add_op(0, 1'b0, 4'd3, 8'h00, 8'h00);
        run_ops(10, used);
        idle(5);

        // Preload the rest of the array from requester 0.
        for (int a = 0; a < 16; a++) begin
            if (a == 5)      add_op(0, 1'b1, 4'(a), 8'hF0, 8'hFF);
            else if (a == 7) add_op(0, 1'b1, 4'(a), 8'h11, 8'hFF);
            else if (a != 3) add_op(0, 1'b1, 4'(a), 8'(a * 29 + 7), 8'hFF);
        end
        run_ops(30, used);
        check_val("preload_cycles", used, 32'd15);
        idle(3);

        // All requesters reading back-to-back: one grant per cycle in rotation.
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < 4; k++) add_op(i, 1'b0, 4'(i * 4 + k), 8'h00, 8'h00);
        end
        run_ops(40, used);
        check_val("rr_cycles", used, 32'd16);
        idle(6);

        // Partial write via RMW, then read the merged word.
        add_op(2, 1'b1, 4'd5, 8'h0F, 8'h3C);
        add_op(2, 1'b0, 4'd5, 8'h00, 8'h00);
        run_ops(15, used);
        check_val("rmw_cycles", used, 32'd5);
        idle(6);

        // Zero-mask write leaves memory untouched.
        add_op(0, 1'b1, 4'd7, 8'hEE, 8'h00);
        add_op(0, 1'b0, 4'd7, 8'h00, 8'h00);
        run_ops(10, used);
        idle(6);

        // Read from requester 1 immediately followed by a partial write from requester 3.
        add_op(1, 1'b0, 4'd3, 8'h00, 8'h00);
        add_op(1, 1'b0, 4'd9, 8'h00, 8'h00);
        add_op(3, 1'b1, 4'd9, 8'h5A, 8'hF0);
        run_ops(20, used);
        idle(6);

        // Reset during RMW_WAIT aborts the merge write and restarts the pointer.
        saved = shadow[11];
        add_op(1, 1'b1, 4'd11, 8'h77, 8'h0F);
        run_ops(10, used);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst        = 1'b0;
        shadow[11] = saved;
        exp_ptr    = 0;
        block_cnt  = 0;
        sb.delete();
        exp_cmd.delete();
        idle(4);
        add_op(2, 1'b0, 4'd11, 8'h00, 8'h00);
        add_op(0, 1'b0, 4'd4, 8'h00, 8'h00);
        run_ops(10, used);
        idle(6);

        check_val("sb_drain",  sb.size(),      32'h0);
        check_val("cmd_drain", exp_cmd.num(),  32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
